// File: rtl/regs_sb_pkg.sv
// regs_sb_pkg: shared constants and helpers for the regs_sb register file
// and its write-pending scoreboard.
package regs_sb_pkg;

  // Default geometry of the register file
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_RD_PORTS = 2;

  // Architectural zero register index and active level of write enables
  localparam int   ZERO_REG     = 0;
  localparam logic WRITE_ENABLE = 1'b1;

  // Low bit of lane 'port' inside a packed bus of 'width'-bit lanes
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regs_sb_scoreboard.sv
// regs_sb_scoreboard: per-register busy bits with flush/alloc/clear priority
// and a registered population count of the busy vector.
module regs_sb_scoreboard
  import regs_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int NREG  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              flush_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  output logic [NREG-1:0]   busy_o,
  output logic [ADDR_W:0]   busy_cnt_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic [ADDR_W:0] cnt_nxt;

  // Next busy vector: flush, then writeback clear, then allocation on top so
  // a same-edge allocation always wins.
  always_comb begin
    busy_nxt = busy_q;
    if (flush_i) begin
      busy_nxt = '0;
    end
    if (clr_i) begin
      busy_nxt[clr_addr_i] = 1'b0;
    end
    if (alloc_i && (alloc_addr_i != ADDR_W'(ZERO_REG))) begin
      busy_nxt[alloc_addr_i] = 1'b1;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Population count of the next busy vector, registered alongside it
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  // Busy vector and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_o <= '0;
    end else begin
      busy_q     <= busy_nxt;
      busy_cnt_o <= cnt_nxt;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regs_sb.sv
// regs_sb: general-purpose register file with RD_PORTS combinational read
// ports, writeback write port with priority over a handshaked JTAG port,
// and an integrated write-pending scoreboard.
// Optional feature: define REGS_SB_BYPASS_EN to forward the active writeback
// value (and its busy clear) to matching read ports in the same cycle.
module regs_sb
  import regs_sb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int RD_PORTS    = DEF_RD_PORTS,
  parameter int RESET_CLEAR = 1,
  localparam int NREG       = 2**ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_we_i,
  input  logic [ADDR_W-1:0]          wb_waddr_i,
  input  logic [DATA_W-1:0]          wb_wdata_i,
  input  logic                       alloc_i,
  input  logic [ADDR_W-1:0]          alloc_addr_i,
  input  logic                       flush_i,
  input  logic [RD_PORTS*ADDR_W-1:0] raddr_i,
  output logic [RD_PORTS*DATA_W-1:0] rdata_o,
  output logic [RD_PORTS-1:0]        rbusy_o,
  output logic [ADDR_W:0]            busy_cnt_o,
  input  logic                       jtag_we_i,
  input  logic [ADDR_W-1:0]          jtag_addr_i,
  input  logic [DATA_W-1:0]          jtag_data_i,
  output logic                       jtag_ready_o,
  output logic [DATA_W-1:0]          jtag_data_o
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy;
  logic              wb_wr;
  logic              jtag_wr;
  logic [ADDR_W-1:0] ra [RD_PORTS];

  // JTAG only gets the array when writeback leaves it idle
  assign jtag_ready_o = (wb_we_i != WRITE_ENABLE);
  assign wb_wr   = (wb_we_i == WRITE_ENABLE) && (wb_waddr_i != ADDR_W'(ZERO_REG));
  assign jtag_wr = (jtag_we_i == WRITE_ENABLE) && jtag_ready_o &&
                   (jtag_addr_i != ADDR_W'(ZERO_REG));

  regs_sb_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .alloc_i      (alloc_i),
    .alloc_addr_i (alloc_addr_i),
    .flush_i      (flush_i),
    .clr_i        (wb_wr),
    .clr_addr_i   (wb_waddr_i),
    .busy_o       (busy),
    .busy_cnt_o   (busy_cnt_o)
  );

  // Register array: reset optionally clears, writeback beats JTAG
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RESET_CLEAR != 0) begin
        for (int i = 0; i < NREG; i++) begin
          regs_q[i] <= '0;
        end
      end
    end else if (wb_wr) begin
      regs_q[wb_waddr_i] <= wb_wdata_i;
    end else if (jtag_wr) begin
      regs_q[jtag_addr_i] <= jtag_data_i;
    end
  end

  // Read ports: array lookup with x0 forced to zero, optional writeback bypass
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      ra[k] = raddr_i[port_lsb(k, ADDR_W) +: ADDR_W];
      if (ra[k] != ADDR_W'(ZERO_REG)) begin
        rdata_o[port_lsb(k, DATA_W) +: DATA_W] = regs_q[ra[k]];
        rbusy_o[k] = busy[ra[k]];
`ifdef REGS_SB_BYPASS_EN
        if (wb_wr && (ra[k] == wb_waddr_i)) begin
          rdata_o[port_lsb(k, DATA_W) +: DATA_W] = wb_wdata_i;
          rbusy_o[k] = alloc_i && (alloc_addr_i == ra[k]);
        end
`endif
      end
    end
  end

  // JTAG read port: direct array view, no bypass
  assign jtag_data_o = (jtag_addr_i == ADDR_W'(ZERO_REG)) ? '0 : regs_q[jtag_addr_i];

endmodule

// File: doc/regs_sb.md
# regs_sb

Parametrised general-purpose register file with an integrated write-pending scoreboard, the next-generation replacement for the core's two-read-port register file. It provides `RD_PORTS` combinational read ports, a writeback write port with priority over a handshaked JTAG debug port, and per-register busy tracking. ID uses the busy tracking to stall on operands still owed by long-latency units (load, divider). It sits between ID (reads, allocation) and EX/writeback (writes, busy clear).

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register address width; register count `NREG = 2**ADDR_W`
- `RD_PORTS`, 2, number of read ports (1..4)
- `RESET_CLEAR`, 1, when 1 reset zeroes every register; when 0 reset leaves register contents untouched

Ports (clock and reset first):
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wb_we_i`  in  1  writeback write enable
- `wb_waddr_i`  in  ADDR_W  writeback address
- `wb_wdata_i`  in  DATA_W  writeback data
- `alloc_i`  in  1  mark `alloc_addr_i` pending (long-latency op issued)
- `alloc_addr_i`  in  ADDR_W  destination being allocated
- `flush_i`  in  1  clear all busy bits (pipeline flush)
- `raddr_i`  in  RD_PORTS*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- `rdata_o`  out  RD_PORTS*DATA_W  packed read data
- `rbusy_o`  out  RD_PORTS  busy flag of each read address
- `busy_cnt_o`  out  ADDR_W+1  number of registers currently busy
- `jtag_we_i`  in  1  JTAG write request, held until accepted
- `jtag_addr_i`  in  ADDR_W  JTAG read/write address
- `jtag_data_i`  in  DATA_W  JTAG write data
- `jtag_ready_o`  out  1  JTAG write accepted this cycle when high together with `jtag_we_i`
- `jtag_data_o`  out  DATA_W  JTAG read data, combinational

## Operation
- Register 0 is hardwired to zero.
  - Writes to it are dropped.
  - Reads of it return 0 and busy 0.
  - Allocation to it is ignored.
- Write arbitration:
  - The writeback write takes effect when `wb_we_i` is high and the address is nonzero.
  - The JTAG write takes effect only when `jtag_we_i && jtag_ready_o`.
  - `jtag_ready_o = !wb_we_i`.
  - The JTAG master holds address and data until it samples ready high.
- Scoreboard, per register busy bit, evaluated each edge in this priority order:
  1. `rst` clears all busy bits.
  2. `flush_i` clears all busy bits, then an `alloc_i` in the same cycle still sets its bit.
  3. `alloc_i` sets busy[alloc_addr].
  4. A writeback write clears busy[wb_waddr].
- Same-edge allocation and writeback to the same address: allocation wins, busy stays 1, data is still written.
- JTAG writes never affect busy bits.
- Allocation of an already-busy register keeps it at 1. The scoreboard does not track multiple outstanding writes to one register; ID must not issue them.
- `busy_cnt_o` is a registered population count of the busy bits, updated together with them. It saturates naturally: maximum value `NREG-1`.
- `jtag_data_o` reads the array directly, with no bypass. Address 0 returns 0.

## Timing
- Reset values:
  - all busy bits 0, `busy_cnt_o` 0
  - `rbusy_o` 0, `jtag_ready_o` = `!wb_we_i`
  - registers 0 if `RESET_CLEAR`=1
- A reset asserted mid-operation discards any write or allocation presented that cycle.
- Write latency is 1 cycle: the array updates at the edge after the write is presented.
- Allocation becomes visible on `rbusy_o` one cycle after `alloc_i`.
- Reads are combinational, with zero latency from `raddr_i`.

## Configuration
- `REGS_SB_BYPASS_EN` defined:
  - Any read port whose address equals `wb_waddr_i`, while a writeback write is active and the address is nonzero, returns `wb_wdata_i` the same cycle.
  - `rbusy_o` for that port reads 0, unless an allocation to the same address is also present.
- Undefined:
  - Reads return array contents only, so the new value appears the cycle after the write.
  - `rbusy_o` stays 1 until the busy bit clears at the edge.

## Structure
- Package `regs_sb_pkg` holds:
  - `ZERO_REG`, `WRITE_ENABLE`
  - the default widths
  - a function for packed-port slicing
- Sub-module `regs_sb_scoreboard` holds the busy vector, the priority logic and the popcount register. The array, the arbitration and the read muxes stay in the top.

## Test plan
- Reset with `RESET_CLEAR`=1, then read x1..x31 -> all data 0, `rbusy_o`=0, `busy_cnt_o`=0.
- Write x5=0xDEADBEEF via writeback, then read port 1 at x5 the same cycle:
  - with bypass: 0xDEADBEEF at once.
  - without bypass: old value, then 0xDEADBEEF the next cycle.
- Allocate x7 -> `rbusy_o`=1 next cycle and `busy_cnt_o`=1. Writeback x7=0x12 -> busy 0 and count 0 the next cycle.
- Allocation and writeback to x9 on the same edge -> x9=data and busy stays 1. Flush together with alloc of x3 -> only x3 remains busy, count=1.
- JTAG write x4=0xA5A5A5A5 while `wb_we_i`=1 for 2 cycles:
  - ready stays 0 for those cycles and x4 is unchanged.
  - the write lands on the 3rd cycle.
  - `jtag_data_o` shows 0xA5A5A5A5 afterwards.
- Write, allocate and JTAG-write x0 with 0xFFFFFFFF -> x0 reads 0, busy 0, count unchanged.
